// File: rtl/sdu_pkg.sv
// rtl/sdu_pkg.sv - shared types and constants for the spectral line buffer
package sdu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNLOAD = 3'd1,
        ST_LOAD   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_SWAP   = 3'd4
    } wr_state_t;

    localparam int DEF_N_BINS = 128;
    localparam int DEF_DIN_W  = 32;

    // Source of the all-ones pattern used when the shifted power overflows POW_W
    localparam logic [63:0] SAT_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/power_calc.sv
// rtl/power_calc.sv - two-stage |X|^2 pipeline: square, then add/shift/saturate
module power_calc
    import sdu_pkg::*;
#(
    parameter int DIN_W = DEF_DIN_W,
    parameter int POW_W = 32,
    parameter int SHIFT = 32,
    parameter int AW    = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [AW-1:0]           in_addr,
    input  logic signed [DIN_W-1:0] re,
    input  logic signed [DIN_W-1:0] im,
    output logic                    out_valid,
    output logic [AW-1:0]           out_addr,
    output logic [POW_W-1:0]        out_pow
);

    // Sign-extend first so the product is computed at full width without truncation
    logic signed [2*DIN_W-1:0] re_x;
    logic signed [2*DIN_W-1:0] im_x;
    logic signed [2*DIN_W-1:0] re_sq;
    logic signed [2*DIN_W-1:0] im_sq;
    logic                      v1;
    logic [AW-1:0]             a1;

    logic [2*DIN_W:0]          sum;
    logic [2*DIN_W:0]          shifted;
    logic                      hi_nz;
    logic [POW_W-1:0]          pow_sat;

    assign re_x = {{DIN_W{re[DIN_W-1]}}, re};
    assign im_x = {{DIN_W{im[DIN_W-1]}}, im};

    // Stage 1: squares of both components, address and valid travel alongside
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            a1    <= '0;
            re_sq <= '0;
            im_sq <= '0;
        end else begin
            v1    <= in_valid;
            a1    <= in_addr;
            re_sq <= re_x * re_x;
            im_sq <= im_x * im_x;
        end
    end

    // Squares are never negative, so the sum is treated as unsigned with one carry bit
    assign sum     = {1'b0, re_sq} + {1'b0, im_sq};
    assign shifted = sum >> SHIFT;
    assign hi_nz   = |(shifted >> POW_W);
    assign pow_sat = hi_nz ? SAT_ALL_ONES[POW_W-1:0] : shifted[POW_W-1:0];

    // Stage 2: register the shifted, saturated power
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_pow   <= '0;
        end else begin
            out_valid <= v1;
            out_addr  <= a1;
            out_pow   <= pow_sat;
        end
    end

endmodule

// File: rtl/spectral_line_buffer.sv
// rtl/spectral_line_buffer.sv - ping-pong FFT power line buffer, optional peak detect via SLB_PEAK_DETECT_EN
module spectral_line_buffer
    import sdu_pkg::*;
#(
    parameter int N_BINS = DEF_N_BINS,
    parameter int DIN_W  = DEF_DIN_W,
    parameter int POW_W  = 32,
    parameter int SHIFT  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fft_done,
    output logic                        fft_unload,
    input  logic                        fft_dv,
    input  logic signed [DIN_W-1:0]     xk_re,
    input  logic signed [DIN_W-1:0]     xk_im,
    output logic                        line_valid,
    input  logic                        line_ready,
    output logic [POW_W-1:0]            line_data,
    output logic                        line_last,
    output logic [15:0]                 drop_cnt
`ifdef SLB_PEAK_DETECT_EN
    ,
    output logic [$clog2(N_BINS)-1:0]   peak_bin,
    output logic [POW_W-1:0]            peak_pow
`endif
);

    localparam int            AW        = $clog2(N_BINS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_BINS - 1);
    localparam logic [AW-1:0] HALF      = AW'(N_BINS / 2);

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [AW-1:0]     beat_cnt;
    logic              flush_cnt;
    logic              wr_bank;
    logic [AW-1:0]     rd_addr;
    logic              rd_free;
    logic              do_swap;
    logic              drop_inc;

    logic              pc_valid;
    logic [AW-1:0]     pc_addr;
    logic [POW_W-1:0]  pc_pow;

    logic              fetch_en;
    logic [AW:0]       fetch_idx;

    logic [POW_W-1:0]  mem [0:2*N_BINS-1];

    // The read side can take a new line when idle or when its last beat leaves this cycle
    assign rd_free   = !line_valid || (line_ready && (rd_addr == LAST_ADDR));
    assign line_last = line_valid && (rd_addr == LAST_ADDR);
    assign drop_inc  = fft_done && (state != ST_IDLE);

    // Write FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM next state, unload request and bank swap decision
    always_comb begin
        state_nxt  = state;
        fft_unload = 1'b0;
        do_swap    = 1'b0;
        case (state)
            ST_IDLE:   if (fft_done) state_nxt = ST_UNLOAD;
            ST_UNLOAD: begin
                fft_unload = 1'b1;
                state_nxt  = ST_LOAD;
            end
            ST_LOAD:   if (fft_dv && (beat_cnt == LAST_ADDR)) state_nxt = ST_FLUSH;
            ST_FLUSH:  if (flush_cnt) state_nxt = ST_SWAP;
            ST_SWAP:   if (rd_free) begin
                do_swap   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Beat and flush counters, write bank toggle and dropped-frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt  <= '0;
            flush_cnt <= 1'b0;
            wr_bank   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (state == ST_UNLOAD) begin
                beat_cnt <= '0;
            end else if ((state == ST_LOAD) && fft_dv) begin
                beat_cnt <= beat_cnt + AW'(1);
            end
            flush_cnt <= (state == ST_FLUSH) ? ~flush_cnt : 1'b0;
            if (do_swap) begin
                wr_bank <= ~wr_bank;
            end
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    power_calc #(
        .DIN_W (DIN_W),
        .POW_W (POW_W),
        .SHIFT (SHIFT),
        .AW    (AW)
    ) u_power_calc (
        .clk       (clk),
        .reset     (reset),
        .in_valid  ((state == ST_LOAD) && fft_dv),
        .in_addr   (beat_cnt + HALF),
        .re        (xk_re),
        .im        (xk_im),
        .out_valid (pc_valid),
        .out_addr  (pc_addr),
        .out_pow   (pc_pow)
    );

    // Bank write; the address already carries the half-spectrum rotation
    always_ff @(posedge clk) begin
        if (pc_valid) begin
            mem[{wr_bank, pc_addr}] <= pc_pow;
        end
    end

    // Select the next word to present: first word of the new line on swap, else the following word
    always_comb begin
        fetch_en  = 1'b0;
        fetch_idx = '0;
        if (do_swap) begin
            fetch_en  = 1'b1;
            fetch_idx = {wr_bank, {AW{1'b0}}};
        end else if (line_valid && line_ready && (rd_addr != LAST_ADDR)) begin
            fetch_en  = 1'b1;
            fetch_idx = {~wr_bank, rd_addr + AW'(1)};
        end
    end

    // Output data register; holds its value while the consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_data <= '0;
        end else if (fetch_en) begin
            line_data <= mem[fetch_idx];
        end
    end

    // Read-side sequencing: start on swap, advance on each accepted beat, stop after the last
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_valid <= 1'b0;
            rd_addr    <= '0;
        end else if (do_swap) begin
            line_valid <= 1'b1;
            rd_addr    <= '0;
        end else if (line_valid && line_ready) begin
            if (rd_addr == LAST_ADDR) begin
                line_valid <= 1'b0;
            end else begin
                rd_addr <= rd_addr + AW'(1);
            end
        end
    end

`ifdef SLB_PEAK_DETECT_EN
    logic [POW_W-1:0] run_pow;
    logic [AW-1:0]    run_bin;
    logic             run_any;

    // Running maximum over the frame being loaded (strict greater keeps the first on ties), latched at swap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_pow  <= '0;
            run_bin  <= '0;
            run_any  <= 1'b0;
            peak_bin <= '0;
            peak_pow <= '0;
        end else begin
            if (state == ST_UNLOAD) begin
                run_any <= 1'b0;
            end else if (pc_valid && (!run_any || (pc_pow > run_pow))) begin
                run_any <= 1'b1;
                run_pow <= pc_pow;
                run_bin <= pc_addr;
            end
            if (do_swap) begin
                peak_bin <= run_bin;
                peak_pow <= run_pow;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spectral_line_buffer.sv
// tb/tb_spectral_line_buffer.sv - randomized scoreboard bench for spectral_line_buffer
module tb_spectral_line_buffer;

    localparam int N  = 128;
    localparam int DW = 32;
    localparam int PW = 32;
    localparam int SH = 0;
    localparam int AW = 7;

    logic                 clk        = 1'b0;
    logic                 reset      = 1'b1;
    logic                 fft_done   = 1'b0;
    logic                 fft_dv     = 1'b0;
    logic                 line_ready = 1'b0;
    logic signed [DW-1:0] xk_re      = '0;
    logic signed [DW-1:0] xk_im      = '0;
    logic                 fft_unload;
    logic                 line_valid;
    logic                 line_last;
    logic [PW-1:0]        line_data;
    logic [15:0]          drop_cnt;
`ifdef SLB_PEAK_DETECT_EN
    logic [AW-1:0]        peak_bin;
    logic [PW-1:0]        peak_pow;
`endif

    always #5 clk = ~clk;

    spectral_line_buffer #(
        .N_BINS (N),
        .DIN_W  (DW),
        .POW_W  (PW),
        .SHIFT  (SH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fft_done   (fft_done),
        .fft_unload (fft_unload),
        .fft_dv     (fft_dv),
        .xk_re      (xk_re),
        .xk_im      (xk_im),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_data  (line_data),
        .line_last  (line_last),
        .drop_cnt   (drop_cnt)
`ifdef SLB_PEAK_DETECT_EN
        ,
        .peak_bin   (peak_bin),
        .peak_pow   (peak_pow)
`endif
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
    } beat_t;

    int    errors      = 0;
    int    checks      = 0;
    int    ready_mode  = 0;
    int    unload_seen = 0;
    int    frames_sent = 0;
    int    drops_model = 0;
    int    beat_no     = 0;
    beat_t exp_q[$];

    logic signed [DW-1:0] fr_re [N];
    logic signed [DW-1:0] fr_im [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Power straight from the definition: |re|^2 + |im|^2, shift, clamp to PW bits
    function automatic logic [PW-1:0] pow_model(input logic signed [DW-1:0] re,
                                                input logic signed [DW-1:0] im);
        logic [DW-1:0]   ar;
        logic [DW-1:0]   ai;
        logic [2*DW:0]   s;
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        s  = (2*DW+1)'(ar) * (2*DW+1)'(ar) + (2*DW+1)'(ai) * (2*DW+1)'(ai);
        s  = s >> SH;
        if ((s >> PW) != 0) return {PW{1'b1}};
        return s[PW-1:0];
    endfunction

    // Consumer: ready pattern per mode, changed just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       line_ready = 1'b1;
                1:       line_ready = ~line_ready;
                2:       line_ready = 1'($urandom_range(0, 1));
                default: line_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (fft_unload) unload_seen++;
    end

    // Monitor: pop expected beat on each transfer, and verify hold during stalls
    logic          prev_stall = 1'b0;
    logic [PW-1:0] hold_data  = '0;
    logic          hold_last  = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(line_valid), 64'(1));
                check("stall_data", 64'(line_data), 64'(hold_data));
                check("stall_last", 64'(line_last), 64'(hold_last));
            end
            if (line_valid && line_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: actual=%0h required=none", line_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(line_data), 64'(e.data));
                    check("beat_last", 64'(line_last), 64'(e.last));
                end
                beat_no++;
            end
            prev_stall = line_valid && !line_ready;
            hold_data  = line_data;
            hold_last  = line_last;
        end
    end

    task automatic wait_room(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() > limit) && (n < 6000)) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > limit) begin
            errors++;
            $display("FAIL drain_timeout: actual=%0d required<=%0d", exp_q.size(), limit);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    // FFT side: fill a frame, request, wait for unload, stream beats, then queue the expected line
    task automatic send_frame(input int kind, input int gaps, input int done_at, input int abort_at);
        logic signed [15:0] t;
        bit                 got;
        beat_t              b;
        int                 k;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: begin fr_re[i] = i;            fr_im[i] = 0;            end
                1: begin fr_re[i] = 32'h7FFFFFFF; fr_im[i] = 32'h7FFFFFFF; end
                2: begin
                    t = 16'($urandom); fr_re[i] = t;
                    t = 16'($urandom); fr_im[i] = t;
                end
                3: begin fr_re[i] = $urandom;     fr_im[i] = $urandom;     end
                4: begin fr_re[i] = (i == 10) ? 1000 : 0; fr_im[i] = 0;    end
                default: begin fr_re[i] = -i;     fr_im[i] = 3 * i;        end
            endcase
        end
        if (kind == 3) fr_re[0] = 32'h80000000;
        // stray sample while idle must be ignored
        fft_dv = 1'b1; xk_re = $urandom; xk_im = $urandom;
        @(posedge clk); #1;
        fft_dv = 1'b0;
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
        frames_sent++;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (fft_unload) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL unload_timeout: actual=0 required=1");
            return;
        end
        @(posedge clk); #1;
        for (k = 0; k < N; k++) begin
            if (k == abort_at) return;
            fft_dv = 1'b1;
            xk_re  = fr_re[k];
            xk_im  = fr_im[k];
            if (k == done_at) begin
                fft_done = 1'b1;
                drops_model++;
            end
            @(posedge clk); #1;
            fft_dv   = 1'b0;
            fft_done = 1'b0;
            if (gaps != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        // stray sample during flush must be ignored
        fft_dv = 1'b1; xk_re = $urandom; xk_im = $urandom;
        @(posedge clk); #1;
        fft_dv = 1'b0;
        for (int j = 0; j < N; j++) begin
            b.data = pow_model(fr_re[(j + N/2) % N], fr_im[(j + N/2) % N]);
            b.last = (j == N - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_line_valid"}, 64'(line_valid), 64'(0));
        check({tag, "_line_last"},  64'(line_last),  64'(0));
        check({tag, "_line_data"},  64'(line_data),  64'(0));
        check({tag, "_drop_cnt"},   64'(drop_cnt),   64'(0));
        check({tag, "_fft_unload"}, 64'(fft_unload), 64'(0));
`ifdef SLB_PEAK_DETECT_EN
        check({tag, "_peak_bin"},   64'(peak_bin),   64'(0));
        check({tag, "_peak_pow"},   64'(peak_pow),   64'(0));
`endif
    endtask

    initial begin
        int u0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // ramp frame under random ready, then saturation frame loaded while it is still read
        ready_mode = 2;
        send_frame(0, 0, -1, -1);
        wait_room(N);
        send_frame(1, 1, -1, -1);

        // 1-0-1 ready toggling
        wait_room(N);
        ready_mode = 1;
        send_frame(2, 1, -1, -1);
        wait_room(0);

        ready_mode = 2;
        send_frame(3, 1, -1, -1);
        wait_room(N);
        send_frame(5, 0, -1, -1);
        wait_room(0);

        // second request during load with the consumer stalled is dropped
        ready_mode = 3;
        u0 = unload_seen;
        send_frame(0, 0, 20, -1);
        repeat (12) @(posedge clk);
        #1;
        check("drop_unloads", 64'(unload_seen - u0), 64'(1));
        check("drop_cnt_one", 64'(drop_cnt), 64'(1));
        ready_mode = 0;
        wait_room(0);

        // reset in the middle of a load discards the partial frame
        ready_mode = 0;
        send_frame(2, 0, -1, 50);
        reset = 1'b0;
        #1 check_reset_outputs("midload");
        drops_model = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send_frame(0, 1, -1, -1);
        wait_room(0);

`ifdef SLB_PEAK_DETECT_EN
        ready_mode = 3;
        send_frame(4, 0, -1, -1);
        repeat (10) @(posedge clk);
        #1;
        check("peak_bin", 64'(peak_bin), 64'(74));
        check("peak_pow", 64'(peak_pow), 64'(1000000));
        ready_mode = 0;
        wait_room(0);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("drop_total", 64'(drop_cnt), 64'(drops_model));
        check("unload_total", 64'(unload_seen), 64'(frames_sent));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
